// File: rtl/sample_word_unpacker.sv
// Unpacks FWFT FIFO sample words into a byte stream (full-res, low-res 8-bit, pad16).
// Optional pad16 format compiled in with `define UNPACK_PAD16_EN.
module sample_word_unpacker #(
    parameter int SAMPLE_WIDTH     = 12,
    parameter int SAMPLES_PER_WORD = 3,
    parameter int WORD_WIDTH       = SAMPLE_WIDTH * SAMPLES_PER_WORD
) (
    input  logic                  clk_usb,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [1:0]            mode,
    input  logic                  low_res_lsb,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_empty,
    output logic                  in_rd,
    output logic [7:0]            out_data,
    output logic                  out_empty,
    input  logic                  out_rd,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  underflow,
    output logic [31:0]           byte_count
);

    localparam int SW   = SAMPLE_WIDTH;
    localparam int SPW  = SAMPLES_PER_WORD;
    localparam int LR_W = 8 * SPW;
`ifdef UNPACK_PAD16_EN
    localparam int PD_W     = 16 * SPW;
    localparam int UNIT_MAX = (WORD_WIDTH > PD_W) ? WORD_WIDTH : PD_W;
`else
    localparam int UNIT_MAX = (WORD_WIDTH > LR_W) ? WORD_WIDTH : LR_W;
`endif
    localparam int ACC_W = UNIT_MAX + 7;
    localparam int CW    = $clog2(ACC_W + 1);

    logic [ACC_W-1:0] acc, acc_sh, acc_nx, unit_al;
    logic [CW-1:0]    cnt, rem, cnt_nx, unit_len;
    logic [1:0]       mode_r;
    logic             lsb_r, flush_pend;
    logic             pop, resid_pop, resid_avail, idle_done;
    logic [LR_W-1:0]  lr_unit;
`ifdef UNPACK_PAD16_EN
    logic [PD_W-1:0]  pd_unit;
`endif

    // Per-sample slicing; sample 0 sits at the MSB end of the word.
    for (genvar i = 0; i < SPW; i++) begin : g_smp
        logic [SW-1:0] s;
        assign s = in_data[WORD_WIDTH-1-i*SW -: SW];
        assign lr_unit[LR_W-1-8*i -: 8] = lsb_r ? s[7:0] : s[SW-1 -: 8];
`ifdef UNPACK_PAD16_EN
        assign pd_unit[PD_W-1-16*i -: 16] = 16'(s);
`endif
    end

    always_comb begin
        unit_al  = {in_data, {(ACC_W-WORD_WIDTH){1'b0}}};
        unit_len = CW'(WORD_WIDTH);
        if (mode_r == 2'b01) begin
            unit_al  = {lr_unit, {(ACC_W-LR_W){1'b0}}};
            unit_len = CW'(LR_W);
        end
`ifdef UNPACK_PAD16_EN
        else if (mode_r == 2'b10) begin
            unit_al  = {pd_unit, {(ACC_W-PD_W){1'b0}}};
            unit_len = CW'(PD_W);
        end
`endif
    end

    assign resid_avail = flush_pend & in_empty & (cnt != '0);
    assign idle_done   = flush_pend & in_empty & (cnt == '0);
    assign out_empty   = (cnt < CW'(8)) & ~resid_avail;
    assign out_data    = acc[ACC_W-1 -: 8];
    assign pop         = out_rd & ~out_empty;
    assign resid_pop   = pop & (cnt < CW'(8));

    // A residual pop drains everything; bits below cnt are always zero.
    always_comb begin
        rem    = cnt;
        acc_sh = acc;
        if (resid_pop) begin
            rem    = '0;
            acc_sh = '0;
        end else if (pop) begin
            rem    = cnt - CW'(8);
            acc_sh = acc << 8;
        end
    end

    assign in_rd  = ~in_empty & (rem < CW'(8)) & ~reset & ~clear;
    assign acc_nx = in_rd ? (acc_sh | (unit_al >> rem)) : acc_sh;
    assign cnt_nx = in_rd ? (rem + unit_len) : rem;

    always_ff @(posedge clk_usb) begin
        if (reset | clear) begin
            acc        <= '0;
            cnt        <= '0;
            mode_r     <= 2'b00;
            lsb_r      <= 1'b0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
            underflow  <= 1'b0;
            byte_count <= '0;
        end else begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            // Format only changes on an empty accumulator with nothing loading.
            if (cnt == '0 && !in_rd) begin
                mode_r <= mode;
                lsb_r  <= low_res_lsb;
            end
            flush_done <= idle_done | resid_pop;
            if (idle_done | resid_pop)
                flush_pend <= 1'b0;
            else if (flush)
                flush_pend <= 1'b1;
            if (out_rd & out_empty)
                underflow <= 1'b1;
            if (pop)
                byte_count <= byte_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_sample_word_unpacker.sv
// Directed + random bench for sample_word_unpacker; scoreboard of expected bytes.
module tb_sample_word_unpacker;

    logic        clk_usb = 1'b0;
    logic        reset, clear, low_res_lsb, in_empty, in_rd;
    logic [1:0]  mode;
    logic [35:0] in_data;
    logic [7:0]  out_data;
    logic        out_empty, out_rd, flush, flush_done, underflow;
    logic [31:0] byte_count;

    always #5 clk_usb = ~clk_usb;

    sample_word_unpacker dut (
        .clk_usb(clk_usb), .reset(reset), .clear(clear), .mode(mode),
        .low_res_lsb(low_res_lsb), .in_data(in_data), .in_empty(in_empty),
        .in_rd(in_rd), .out_data(out_data), .out_empty(out_empty),
        .out_rd(out_rd), .flush(flush), .flush_done(flush_done),
        .underflow(underflow), .byte_count(byte_count)
    );

    logic [35:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [63:0] bb;
    int          nb, n_assert, n_fail, pops, loads, exp_bc;
    bit          rnd_gate, rnd_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        in_empty = (fifo_q.size() == 0) || (rnd_gate && $urandom_range(0, 2) == 0);
        in_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic exp_byte(input logic [7:0] b);
        exp_q.push_back(b);
        exp_bc++;
    endtask

    task automatic push_raw(input logic [35:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    // Full-res reference: plain bit concatenation of the words, MSB first.
    task automatic push_full(input logic [35:0] w);
        bb = (bb << 36) | 64'(w);
        nb += 36;
        while (nb >= 8) begin
            exp_byte(8'(bb >> (nb - 8)));
            nb -= 8;
        end
        push_raw(w);
    endtask

    task automatic cyc();
        @(negedge clk_usb);
        if (out_rd && !out_empty) begin
            pops++;
            if (exp_q.size() == 0) check("sb_has_byte", 64'(exp_q.size()), 1);
            else check("byte", 64'(out_data), 64'(exp_q.pop_front()));
        end
        if (in_rd) begin
            loads++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        @(posedge clk_usb);
        #1;
        refresh();
        if (rnd_rd) out_rd = 1'($urandom_range(0, 1));
    endtask

    task automatic sync_clear(input bit use_reset);
        if (use_reset) reset = 1'b1; else clear = 1'b1;
        cyc();
        reset = 1'b0;
        clear = 1'b0;
        exp_q.delete();
        nb = 0; bb = '0; exp_bc = 0;
    endtask

    task automatic drain(input int limit, input string tag);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) cyc();
        check(tag, 64'(exp_q.size()), 0);
    endtask

    task automatic pop_n(input int n);
        int p0;
        p0 = pops;
        out_rd = 1'b1;
        for (int i = 0; i < 20 && (pops - p0) < n; i++) cyc();
        out_rd = 1'b0;
        check("pop_n_reached", 64'(pops - p0), 64'(n));
    endtask

    initial begin
        int l0, fd_cnt, fd_idx;
        bit ne_seen;
        n_assert = 0; n_fail = 0; pops = 0; loads = 0; exp_bc = 0; nb = 0; bb = '0;
        rnd_gate = 0; rnd_rd = 0;
        reset = 1'b1; clear = 1'b0; mode = 2'b00; low_res_lsb = 1'b0;
        out_rd = 1'b0; flush = 1'b0;
        refresh();
        repeat (2) cyc();
        // reset values, and in_rd held low by reset even with data waiting
        push_raw(36'hABCDEF123);
        #1;
        check("rst_in_rd", 64'(in_rd), 0);
        check("rst_out_empty", 64'(out_empty), 1);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_flush_done", 64'(flush_done), 0);
        check("rst_underflow", 64'(underflow), 0);
        check("rst_byte_count", 64'(byte_count), 0);
        fifo_q.delete();
        refresh();
        reset = 1'b0;
        cyc();

        // 1: two full-res words, out_rd held high
        out_rd = 1'b1;
        l0 = loads;
        push_full(36'hABCDEF123);
        push_full(36'h456789ABC);
        drain(50, "t1_drain");
        check("t1_byte_count", 64'(byte_count), 64'(exp_bc));
        check("t1_loads", 64'(loads - l0), 2);

        // 2: low-res, MSB then LSB selection
        mode = 2'b01; low_res_lsb = 1'b0;
        repeat (2) cyc();
        exp_byte(8'hAB); exp_byte(8'hDE); exp_byte(8'h12);
        push_raw(36'hABCDEF123);
        drain(30, "t2_msb_drain");
        low_res_lsb = 1'b1;
        repeat (2) cyc();
        exp_byte(8'hBC); exp_byte(8'hEF); exp_byte(8'h23);
        push_raw(36'hABCDEF123);
        drain(30, "t2_lsb_drain");

        // 3: pad16 (or full-res when pad16 is not built)
        mode = 2'b10; low_res_lsb = 1'b0;
        repeat (2) cyc();
`ifdef UNPACK_PAD16_EN
        exp_byte(8'h0A); exp_byte(8'hBC); exp_byte(8'h0D);
        exp_byte(8'hEF); exp_byte(8'h01); exp_byte(8'h23);
        push_raw(36'hABCDEF123);
`else
        push_full(36'hABCDEF123);
`endif
        drain(40, "t3_drain");
        repeat (2) cyc();
        check("t3_out_empty", 64'(out_empty), 1);
        mode = 2'b00;
        sync_clear(0);
        check("t3_clear_count", 64'(byte_count), 0);

        // 4: flush of a residual nibble, then flush with nothing left
        repeat (2) cyc();
        push_full(36'hABCDEF123);
        drain(30, "t4_drain");
        repeat (3) cyc();
        check("t4_resid_held", 64'(out_empty), 1);
        check("t4_no_fd_yet", 64'(flush_done), 0);
        flush = 1'b1;
        exp_byte(8'(bb << (8 - nb)));
        nb = 0;
        cyc();
        flush = 1'b0;
        drain(10, "t4_resid_drain");
        check("t4_fd_after_pop", 64'(flush_done), 1);
        check("t4_empty_after", 64'(out_empty), 1);
        cyc();
        check("t4_fd_single", 64'(flush_done), 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        fd_cnt = 0; fd_idx = -1; ne_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (flush_done) begin
                fd_cnt++;
                if (fd_idx < 0) fd_idx = i;
            end
            if (!out_empty) ne_seen = 1;
            cyc();
        end
        check("t4_fd2_pulses", 64'(fd_cnt), 1);
        check("t4_fd2_at", 64'(fd_idx), 1);
        check("t4_fd2_no_byte", 64'(ne_seen), 0);

        // 5: random out_rd and FIFO availability, 1000 random words
        rnd_gate = 1; rnd_rd = 1;
        for (int i = 0; i < 1000; i++) push_full({4'($urandom), 32'($urandom)});
        drain(40000, "t5_drain");
        rnd_gate = 0; rnd_rd = 0; out_rd = 1'b0;
        refresh();
        cyc();
        check("t5_byte_count", 64'(byte_count), 64'(exp_bc));
        check("t5_out_empty", 64'(out_empty), 1);

        // 6: reset/clear mid-word, underflow stickiness
        check("t6_uf_sticky", 64'(underflow), 1);
        push_full(36'hABCDEF123);
        pop_n(2);
        check("t6_more_pending", 64'(out_empty), 0);
        sync_clear(1);
        check("t6_rst_empty", 64'(out_empty), 1);
        check("t6_rst_count", 64'(byte_count), 0);
        check("t6_rst_uf", 64'(underflow), 0);
        out_rd = 1'b1;
        cyc();
        out_rd = 1'b0;
        check("t6_uf_set", 64'(underflow), 1);
        sync_clear(0);
        check("t6_clr_uf", 64'(underflow), 0);
        check("t6_clr_count", 64'(byte_count), 0);
        push_full(36'h456789ABC);
        pop_n(2);
        sync_clear(0);
        check("t6_clr_empty", 64'(out_empty), 1);
        check("t6_clr_count2", 64'(byte_count), 0);
        out_rd = 1'b1;
        push_full(36'hABCDEF123);
        drain(30, "t6_restart_drain");
        check("t6_restart_count", 64'(byte_count), 64'(exp_bc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_word_unpacker.md
Name: sample_word_unpacker

Overview:
Single-clock unpacker on the USB side of the capture path. Pops packed sample words from a first-word-fall-through FIFO and presents them to the USB reader as a byte stream. Generalises the fixed 3×12-bit/36-bit word unpacking to any sample width and samples-per-word, with three output formats and an explicit end-of-capture flush for residual bits.

Parameters:
SAMPLE_WIDTH, 12, bits per sample; legal range 8..16.
SAMPLES_PER_WORD, 3, samples per input word; sample 0 is at the MSB end.
WORD_WIDTH, SAMPLE_WIDTH*SAMPLES_PER_WORD, input word width. Derived; do not override.

Ports:
clk_usb  in  1  the only clock
reset  in  1  synchronous, active-high
clear  in  1  synchronous, active-high; same effect as reset on internal state; the FIFO is not touched
mode  in  2  00 full-res packed, 01 low-res 8 bit/sample, 10 pad16, 11 treated as 00
low_res_lsb  in  1  in low-res mode, take sample[7:0] instead of sample[SW-1 -: 8]
in_data  in  WORD_WIDTH  FWFT FIFO head word
in_empty  in  1  FIFO empty
in_rd  out  1  combinational pop; in_data is consumed in the same cycle
out_data  out  8  current byte; combinational from registered state
out_empty  out  1  no byte available
out_rd  in  1  byte pop
flush  in  1  single-cycle pulse: end of capture, emit residual bits
flush_done  out  1  single-cycle pulse when flush completes
underflow  out  1  sticky: out_rd seen while out_empty
byte_count  out  32  bytes popped since reset/clear; wraps at 2^32

Behaviour:
- State: bit accumulator acc (UNIT_MAX+7 bits, MSB-aligned valid bits), bit count cnt, mode_r, lsb_r, flush_pend.
- Unit length U by mode_r: full = WORD_WIDTH; low-res = 8*SPW; pad16 = 16*SPW. UNIT_MAX is the maximum U over compiled modes.
- Unit construction, samples in order 0..SPW-1:
  - full: in_data as-is.
  - low-res: 8 bits per sample, selected by lsb_r.
  - pad16: each sample zero-extended to 16 bits, right-justified.
- mode_r and lsb_r load from mode and low_res_lsb only on cycles where cnt==0 and no load occurs. Otherwise a change is deferred; the stream never mixes formats mid-word.
- pop = out_rd & ~out_empty. rem = cnt − (pop ? 8 : 0), or 0 for a flush-residual pop.
- in_rd = ~in_empty & (rem < 8) & ~reset & ~clear. On load, the unit is appended directly below the remaining valid bits and cnt_next = rem + U. A pop and a load in the same cycle are legal and lose no data.
- out_empty = (cnt < 8) & ~(flush_pend & in_empty & cnt > 0).
- out_data = acc top 8 bits. For a residual byte (cnt 1..7), the valid bits are MSB-aligned and the low bits are zero.
- out_rd while out_empty: ignored; underflow set until reset/clear.
- Flush:
  - flush sets flush_pend; loads continue normally.
  - When in_empty & cnt < 8: if cnt == 0, pulse flush_done next cycle and clear flush_pend; otherwise expose the residual byte, and its pop sets cnt = 0, pulses flush_done and clears flush_pend.
  - flush while flush_pend is already set: no effect.
- byte_count increments on every pop.
- Reset values: in_rd 0 (combinationally forced), out_empty 1, out_data 0, flush_done 0, underflow 0, byte_count 0, cnt 0, flush_pend 0, mode_r 00, lsb_r 0.
- Reset or clear mid-stream discards accumulator contents immediately. flush_done is not pulsed.
- Latency: a word popped at cycle N has its first byte valid at N+1.

Optional Feature:
UNPACK_PAD16_EN.
- Defined: mode 10 selects pad16, and UNIT_MAX covers 16*SPW.
- Undefined: mode 10 behaves as 00, the pad16 logic is absent, and UNIT_MAX = max(WORD_WIDTH, 8*SPW).

Test Plan:
1. Defaults, mode 00, FIFO words 36'hABCDEF123 then 36'h456789ABC, out_rd held high → bytes AB CD EF 12 34 56 78 9A BC; byte_count = 9; in_rd pulses exactly twice.
2. Mode 01, word 36'hABCDEF123: low_res_lsb = 0 → AB DE 12; low_res_lsb = 1 → BC EF 23.
3. With UNPACK_PAD16_EN, mode 10, word 36'hABCDEF123 → 0A BC 0D EF 01 23. Without the macro, the same stimulus gives the full-res bytes AB CD EF 12 (residual 4'h3 held).
4. Mode 00, single word 36'hABCDEF123, then FIFO empty, then flush → AB CD EF 12 30, then a flush_done pulse one cycle after the last pop. A second flush with cnt == 0 → flush_done next cycle, no byte.
5. Mode 00, out_rd toggling randomly, FIFO toggling empty, 1000 random words → byte stream equals the reference bit concatenation. No pop while out_empty; no overflow of acc.
6. Reset asserted after 2 bytes of a word, then clear exercised the same way; underflow provoked by out_rd while empty → out_empty 1, byte_count 0, underflow cleared by the reset/clear; next word's unpacking starts at its MSB.
